// File: rtl/cpu_core_if.sv
// Bus bundle for cpu_core: run control, instruction-memory write port and status outputs.
// The core takes the slave modport; whatever loads programs and watches results takes master.
interface cpu_core_if #(
    parameter int DATA_W  = 16,
    parameter int IMEM_AW = 8
);
    logic               start;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [15:0]        imem_wdata;
    logic [IMEM_AW-1:0] pc;
    logic [DATA_W-1:0]  result;
    logic               result_valid;
    logic               busy;
    logic               halted;

    modport master (
        output start, imem_we, imem_waddr, imem_wdata,
        input  pc, result, result_valid, busy, halted
    );

    modport slave (
        input  start, imem_we, imem_waddr, imem_wdata,
        output pc, result, result_valid, busy, halted
    );
endinterface

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle CPU, 16-bit instructions, 8 registers, 4 cycles per instruction.
// Optional macro CPU_BRANCH_EN turns opcode A into BZ (branch if register zero).
module cpu_core #(
    parameter int DATA_W  = 16,
    parameter int IMEM_AW = 8
) (
    input  logic      clk,
    input  logic      reset,
    cpu_core_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;
`ifdef CPU_BRANCH_EN
    localparam logic [3:0] OP_BZ   = 4'hA;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [15:0]        imem [2**IMEM_AW];
    logic [DATA_W-1:0]  regs [8];
    logic [IMEM_AW-1:0] pc_q;
    logic [DATA_W-1:0]  result_q;
    logic               result_valid_q;
    logic               busy_d, halted_d;

    logic [15:0]        ir_p0;
    logic [DATA_W-1:0]  op_a_p1, op_b_p1;
    logic [DATA_W-1:0]  res_p2;
    logic               vld_p2;
`ifdef CPU_BRANCH_EN
    logic               br_taken_p2;
`endif

    logic [3:0] op;
    logic [2:0] rd, rs1, rs2, rs1_sel;
    logic       imem_wr_ok;

    assign op  = ir_p0[15:12];
    assign rd  = ir_p0[11:9];
    assign rs1 = ir_p0[8:6];
    assign rs2 = ir_p0[5:3];
    // BZ tests the register named in the rd field, so route it through the rs1 read port.
`ifdef CPU_BRANCH_EN
    assign rs1_sel = (op == OP_BZ) ? rd : rs1;
`else
    assign rs1_sel = rs1;
`endif
    assign imem_wr_ok = bus.imem_we && (state_q == S_IDLE || state_q == S_HALT);

    function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] f,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (f)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = (b >= DATA_W'(DATA_W)) ? '0 : (a << b);
            OP_SHR:  r = (b >= DATA_W'(DATA_W)) ? '0 : (a >> b);
            OP_NOT:  r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef CPU_BRANCH_EN
    function automatic logic [IMEM_AW-1:0] br_target_f(input logic [IMEM_AW-1:0] pc_cur,
                                                       input logic [8:0] off9);
        logic signed [IMEM_AW-1:0] off;
        off = IMEM_AW'($signed(off9));
        return pc_cur + $unsigned(off);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = 1'b0;
        halted_d = 1'b0;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_HALT: begin
                halted_d = 1'b1;
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH:  begin busy_d = 1'b1; state_d = S_DECODE; end
            S_DECODE: begin busy_d = 1'b1; state_d = S_EXEC;   end
            S_EXEC:   begin busy_d = 1'b1; state_d = S_WB;     end
            S_WB: begin
                busy_d  = 1'b1;
                state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Program memory survives reset; it only accepts writes while the core is parked.
    always_ff @(posedge clk) begin
        if (imem_wr_ok) imem[bus.imem_waddr] <= bus.imem_wdata;
    end

    always_ff @(posedge clk) begin
        case (state_q)
            // p0: instruction fetch
            S_FETCH:  ir_p0 <= imem[pc_q];
            // p1: operand read
            S_DECODE: begin
                op_a_p1 <= regs[rs1_sel];
                op_b_p1 <= regs[rs2];
            end
            // p2: ALU / immediate result
            S_EXEC:   res_p2 <= (op == OP_LDI) ? DATA_W'(ir_p0[7:0]) : alu_f(op, op_a_p1, op_b_p1);
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            vld_p2         <= 1'b0;
`ifdef CPU_BRANCH_EN
            br_taken_p2    <= 1'b0;
`endif
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: if (bus.start) pc_q <= '0;
                S_EXEC: begin
                    vld_p2 <= (op <= OP_LDI);
`ifdef CPU_BRANCH_EN
                    br_taken_p2 <= (op == OP_BZ) && (op_a_p1 == '0);
`endif
                end
                // writeback and next-pc selection
                S_WB: begin
                    if (vld_p2) begin
                        regs[rd]       <= res_p2;
                        result_q       <= res_p2;
                        result_valid_q <= 1'b1;
                    end
                    if (op == OP_JMP)
                        pc_q <= IMEM_AW'(ir_p0[11:0]);
                    else if (op == OP_HALT)
                        pc_q <= pc_q;
`ifdef CPU_BRANCH_EN
                    else if (br_taken_p2)
                        pc_q <= br_target_f(pc_q, ir_p0[8:0]);
`endif
                    else
                        pc_q <= pc_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_d;
    assign bus.halted       = halted_d;
endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core (DATA_W=16, IMEM_AW=4); writeback values are checked
// against a queue of expected results filled as each program is loaded.
module tb_cpu_core;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [DW-1:0] exp_q[$];

    cpu_core_if #(.DATA_W(DW), .IMEM_AW(AW)) bus ();
    cpu_core #(.DATA_W(DW), .IMEM_AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (bus.result_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_extra: got pulse result=%0h expected no pulse", bus.result);
            end else begin
                chk("sb_result", {16'h0, bus.result}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [15:0] ins(input logic [3:0] o, input logic [2:0] d,
                                        input logic [2:0] a, input logic [2:0] b);
        return {o, d, a, b, 3'b000};
    endfunction
    function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] imm);
        return {4'h8, d, 1'b0, imm};
    endfunction

    localparam logic [15:0] HALT = 16'hF000;
    localparam logic [15:0] NOP  = 16'hB000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] w);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = a;
        bus.imem_wdata = w;
        tick();
        bus.imem_we    = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && bus.halted !== 1'b1; i++) tick();
        chk(tag, bus.halted, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.imem_we = 1'b0;
        bus.imem_waddr = '0;
        bus.imem_wdata = '0;
        tick();
        tick();
        chk("rst_pc", bus.pc, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_valid", bus.result_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_halted", bus.halted, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", bus.busy, 0);

        // LDI/LDI/SUB/HALT with cycle-exact pulse timing
        load(0, ldi(1, 8'd5));
        load(1, ldi(2, 8'd3));
        load(2, ins(4'h1, 3, 1, 2));
        load(3, HALT);
        exp_q.push_back(16'd5);
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd2);
        do_start();
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("t030_valid_c%0d", k), bus.result_valid,
                ((k % 4 == 0) && k <= 12) ? 1 : 0);
            if (k == 15) begin
                chk("t030_halted_c15", bus.halted, 0);
                chk("t030_busy_c15", bus.busy, 1);
            end
        end
        chk("t030_halted_c16", bus.halted, 1);
        chk("t030_pc", bus.pc, 3);

        // ALU coverage, shift overflow and ADD wrap
        load(0, ldi(1, 8'hFF));            exp_q.push_back(16'h00FF);
        load(1, ldi(2, 8'd20));            exp_q.push_back(16'h0014);
        load(2, ins(4'h5, 3, 1, 2));       exp_q.push_back(16'h0000);
        load(3, ins(4'h7, 4, 0, 0));       exp_q.push_back(16'hFFFF);
        load(4, ldi(5, 8'd1));             exp_q.push_back(16'h0001);
        load(5, ins(4'h0, 6, 4, 5));       exp_q.push_back(16'h0000);
        load(6, ldi(2, 8'd4));             exp_q.push_back(16'h0004);
        load(7, ins(4'h5, 3, 1, 2));       exp_q.push_back(16'h0FF0);
        load(8, ins(4'h6, 7, 3, 2));       exp_q.push_back(16'h00FF);
        load(9, ins(4'h1, 7, 0, 5));       exp_q.push_back(16'hFFFF);
        load(10, ins(4'h4, 7, 4, 1));      exp_q.push_back(16'hFF00);
        load(11, ins(4'h2, 7, 4, 1));      exp_q.push_back(16'h00FF);
        load(12, ins(4'h3, 7, 3, 1));      exp_q.push_back(16'h0FFF);
        load(13, HALT);
        do_start();
        run_to_halt("t031_halt", 100);
        chk("t031_pc", bus.pc, 13);
        chk("t031_drain", exp_q.size(), 0);

        // imem write and start while busy are ignored; write while halted sticks
        load(0, ldi(1, 8'h11));
        load(1, ldi(2, 8'h22));
        load(2, HALT);
        exp_q.push_back(16'h11);
        exp_q.push_back(16'h22);
        do_start();
        tick();
        tick();
        load(1, ldi(2, 8'h77));
        tick();
        do_start();
        run_to_halt("t033_halt_a", 60);
        chk("t033_pc_a", bus.pc, 2);
        chk("t033_drain_a", exp_q.size(), 0);
        load(1, ldi(2, 8'h77));
        exp_q.push_back(16'h11);
        exp_q.push_back(16'h77);
        do_start();
        run_to_halt("t033_halt_b", 60);
        chk("t033_drain_b", exp_q.size(), 0);

        // same-cycle start and imem write to address 0
        exp_q.push_back(16'h5A);
        exp_q.push_back(16'h77);
        bus.imem_we = 1'b1;
        bus.imem_waddr = 0;
        bus.imem_wdata = ldi(3, 8'h5A);
        bus.start = 1'b1;
        tick();
        bus.imem_we = 1'b0;
        bus.start = 1'b0;
        run_to_halt("t024_halt", 60);
        chk("t024_drain", exp_q.size(), 0);

        // JMP to the last address, then pc wraps to 0
        load(0, {4'h9, 12'h00F});
        load(4'hF, NOP);
        do_start();
        repeat (4) tick();
        chk("t032_pc_jmp", bus.pc, 4'hF);
        repeat (4) tick();
        chk("t032_pc_wrap", bus.pc, 0);
        pulse_reset();
        chk("t032_rst_busy", bus.busy, 0);

        // reset in EXECUTE of LDI r1,0x55
        load(0, ldi(1, 8'h55));
        load(1, HALT);
        do_start();
        tick();
        tick();
        chk("t029_busy_exec", bus.busy, 1);
        pulse_reset();
        chk("t029_pc", bus.pc, 0);
        chk("t029_busy", bus.busy, 0);
        chk("t029_halted", bus.halted, 0);
        chk("t029_valid", bus.result_valid, 0);
        chk("t029_result", bus.result, 0);
        repeat (4) tick();
        load(0, ins(4'h0, 2, 1, 0));
        exp_q.push_back(16'h0000);
        do_start();
        run_to_halt("t029_halt", 40);
        chk("t029_pc_halt", bus.pc, 1);
        chk("t029_drain", exp_q.size(), 0);

        // BZ r1,-2 at address 4: taken when r1 == 0 (only with the branch option)
        load(0, ldi(1, 8'd0));
        load(1, NOP);
        load(2, NOP);
        load(3, NOP);
        load(4, {4'hA, 3'd1, 9'h1FE});
        load(5, HALT);
        exp_q.push_back(16'h0);
        do_start();
        repeat (20) tick();
`ifdef CPU_BRANCH_EN
        chk("t034_pc_taken", bus.pc, 2);
`else
        chk("t034_pc_taken", bus.pc, 5);
`endif
        pulse_reset();
        load(0, ldi(1, 8'd1));
        exp_q.push_back(16'h1);
        do_start();
        repeat (20) tick();
        chk("t034_pc_not_taken", bus.pc, 5);
        run_to_halt("t034_halt", 20);
        chk("t034_pc_halt", bus.pc, 5);
        chk("t034_drain", exp_q.size(), 0);
        pulse_reset();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
